// File: rtl/uart_wb_loader_if.sv
// UART handshake and Wishbone classic master bundle for uart_wb_loader.
// master = the loader, slave = the uart/interconnect side.
interface uart_wb_loader_if;
   logic [7:0]  rx_data;
   logic        rx_avail;
   logic        rx_error;
   logic        rx_ack;
   logic [7:0]  tx_data;
   logic        tx_wr;
   logic        tx_busy;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o;
   logic        wb_stb_o;
   logic        wb_cyc_o;
   logic        wb_ack_i;

   modport master (
      input  rx_data, rx_avail, rx_error, tx_busy, wb_dat_i, wb_ack_i,
      output rx_ack, tx_data, tx_wr, wb_adr_o, wb_dat_o, wb_sel_o,
             wb_we_o, wb_stb_o, wb_cyc_o
   );

   modport slave (
      output rx_data, rx_avail, rx_error, tx_busy, wb_dat_i, wb_ack_i,
      input  rx_ack, tx_data, tx_wr, wb_adr_o, wb_dat_o, wb_sel_o,
             wb_we_o, wb_stb_o, wb_cyc_o
   );
endinterface

// File: rtl/uart_wb_loader.sv
// UART-to-Wishbone command bridge: R (0x52) word read, W (0x57) word write, P (0x50) ping.
// Define UART_WB_LOADER_TIMEOUT_EN to abandon partial frames after timeout_cycles idle clocks.
module uart_wb_loader #(
   parameter int unsigned timeout_cycles = 1000000
) (
   input  logic              clk,
   input  logic              reset,
   uart_wb_loader_if.master  bus,
   output logic              busy
);

   typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, BUS, TX, TXG, TXW} state_t;

   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] CMD_PING  = 8'h50;
   localparam logic [7:0] ACK_BYTE  = 8'h06;
   localparam logic [7:0] NAK_BYTE  = 8'h15;

   state_t      state;
   logic [7:0]  cmd;
   logic        cmd_err;
   logic [1:0]  byte_cnt;
   logic [31:0] resp_sr;
   logic [1:0]  resp_cnt;
   logic        take;

   // A byte stays pending until the cycle after rx_ack, so the guard stops a second capture.
   assign take            = bus.rx_avail && !bus.rx_ack;
   assign bus.tx_data     = resp_sr[31:24];
   assign bus.wb_sel_o    = 4'hF;
   assign busy            = (state != IDLE);

`ifdef UART_WB_LOADER_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(timeout_cycles + 1);
   logic [TMO_W-1:0] tmo_cnt;
`endif

   // NOTE: every register here uses non-blocking assignments, so all branches see pre-edge values
   // and a later assignment in the same edge (timeout abort) cleanly overrides an earlier one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         cmd          <= '0;
         cmd_err      <= 1'b0;
         byte_cnt     <= '0;
         resp_sr      <= '0;
         resp_cnt     <= '0;
         bus.rx_ack   <= 1'b0;
         bus.tx_wr    <= 1'b0;
         bus.wb_adr_o <= '0;
         bus.wb_dat_o <= '0;
         bus.wb_we_o  <= 1'b0;
         bus.wb_stb_o <= 1'b0;
         bus.wb_cyc_o <= 1'b0;
`ifdef UART_WB_LOADER_TIMEOUT_EN
         tmo_cnt      <= '0;
`endif
      end else begin
         bus.rx_ack <= 1'b0;
         bus.tx_wr  <= 1'b0;

         case (state)
            IDLE: begin
               if (take) begin
                  bus.rx_ack <= 1'b1;
                  cmd        <= bus.rx_data;
                  cmd_err    <= bus.rx_error;
                  state      <= CMD;
               end
            end

            CMD: begin
               byte_cnt <= '0;
               if (cmd_err) begin
                  resp_sr   <= {NAK_BYTE, 24'h0};
                  resp_cnt  <= '0;
                  bus.tx_wr <= 1'b1;
                  state     <= TX;
               end else begin
                  case (cmd)
                     CMD_READ, CMD_WRITE: state <= ADDR;
                     CMD_PING: begin
                        resp_sr   <= {ACK_BYTE, 24'h0};
                        resp_cnt  <= '0;
                        bus.tx_wr <= 1'b1;
                        state     <= TX;
                     end
                     default: begin
                        resp_sr   <= {NAK_BYTE, 24'h0};
                        resp_cnt  <= '0;
                        bus.tx_wr <= 1'b1;
                        state     <= TX;
                     end
                  endcase
               end
            end

            ADDR, DATA: begin
               if (take) begin
                  bus.rx_ack <= 1'b1;
                  byte_cnt   <= byte_cnt + 2'd1;
                  if (bus.rx_error) begin
                     resp_sr   <= {NAK_BYTE, 24'h0};
                     resp_cnt  <= '0;
                     bus.tx_wr <= 1'b1;
                     state     <= TX;
                  end else begin
                     if (state == ADDR)
                        bus.wb_adr_o <= {bus.wb_adr_o[23:0], bus.rx_data};
                     else
                        bus.wb_dat_o <= {bus.wb_dat_o[23:0], bus.rx_data};
                     if (byte_cnt == 2'd3) begin
                        if (state == ADDR && cmd == CMD_WRITE) begin
                           state <= DATA;
                        end else begin
                           bus.wb_cyc_o <= 1'b1;
                           bus.wb_stb_o <= 1'b1;
                           bus.wb_we_o  <= (cmd == CMD_WRITE);
                           state        <= BUS;
                        end
                     end
                  end
               end
            end

            BUS: begin
               if (bus.wb_ack_i) begin
                  bus.wb_cyc_o <= 1'b0;
                  bus.wb_stb_o <= 1'b0;
                  bus.wb_we_o  <= 1'b0;
                  if (bus.wb_we_o) begin
                     resp_sr  <= {ACK_BYTE, 24'h0};
                     resp_cnt <= '0;
                  end else begin
                     resp_sr  <= bus.wb_dat_i;
                     resp_cnt <= 2'd3;
                  end
                  bus.tx_wr <= 1'b1;
                  state     <= TX;
               end
            end

            TX:  state <= TXG;
            TXG: state <= TXW;

            TXW: begin
               if (!bus.tx_busy) begin
                  if (resp_cnt == 2'd0) begin
                     state <= IDLE;
                  end else begin
                     resp_cnt  <= resp_cnt - 2'd1;
                     resp_sr   <= {resp_sr[23:0], 8'h00};
                     bus.tx_wr <= 1'b1;
                     state     <= TX;
                  end
               end
            end

            default: state <= IDLE;
         endcase

`ifdef UART_WB_LOADER_TIMEOUT_EN
         // Idle gap inside a frame: drop it without reply or bus cycle.
         if (state == ADDR || state == DATA) begin
            if (take) begin
               tmo_cnt <= '0;
            end else if (tmo_cnt == TMO_W'(timeout_cycles - 1)) begin
               tmo_cnt <= '0;
               state   <= IDLE;
            end else begin
               tmo_cnt <= tmo_cnt + 1'b1;
            end
         end else begin
            tmo_cnt <= '0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_uart_wb_loader.sv
// Self-checking bench for uart_wb_loader: protocol-level model feeding one negedge compare process.
// Honours UART_WB_LOADER_TIMEOUT_EN for the inter-byte timeout scenario.
module tb_uart_wb_loader;

   typedef struct {
      logic [31:0] adr;
      logic [31:0] dat;
      logic        we;
   } wb_txn_t;

   logic clk;
   logic reset;
   logic busy;

   uart_wb_loader_if bus ();

   uart_wb_loader #(.timeout_cycles(100)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic [7:0]  exp_tx [$];
   wb_txn_t     exp_wb [$];
   logic [7:0]  tx_log [$];
   wb_txn_t     wb_log [$];
   int          tx_count = 0;
   int          wb_count = 0;

   int          slave_ws = 0;
   logic [31:0] slave_rd = 32'h0;
   int          stb_cnt = 0;
   int          stb_run = 0;
   int          last_stb_len = 0;
   int          busy_left = 0;
   int          cyc_no = 0;
   int          last_ack_cyc = 0;
   int          lat_budget = 2;
   bit          first_tx_pending = 0;
   bit          prev_rx_ack = 0;
   bit          prev_tx_wr = 0;

   logic [7:0]  frame [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Compare process: uart tx model, Wishbone slave model and per-cycle invariants.
   always @(negedge clk) begin
      if (reset) begin
         bus.wb_ack_i = 1'b0;
         bus.tx_busy  = 1'b0;
         stb_cnt      = 0;
         stb_run      = 0;
         busy_left    = 0;
         prev_rx_ack  = 0;
         prev_tx_wr   = 0;
      end else begin
         cyc_no++;
         check("wb_sel", {28'h0, bus.wb_sel_o}, 32'hF);
         check("cyc_eq_stb", {31'h0, bus.wb_cyc_o}, {31'h0, bus.wb_stb_o});
         if (prev_rx_ack) check("rx_ack_one_cycle", {31'h0, bus.rx_ack}, 32'h0);
         if (prev_tx_wr)  check("tx_wr_one_cycle", {31'h0, bus.tx_wr}, 32'h0);
         if (bus.rx_ack) last_ack_cyc = cyc_no;

         if (bus.tx_wr) begin
            check("tx_wr_while_busy", {31'h0, bus.tx_busy}, 32'h0);
            check("busy_during_tx", {31'h0, busy}, 32'h1);
            tx_log.push_back(bus.tx_data);
            tx_count++;
            check("tx_expected", {31'h0, exp_tx.size() > 0}, 32'h1);
            if (exp_tx.size() > 0) check("tx_data", {24'h0, bus.tx_data}, {24'h0, exp_tx.pop_front()});
            if (first_tx_pending) begin
               check("tx_latency", {31'h0, (cyc_no - last_ack_cyc) <= lat_budget}, 32'h1);
               first_tx_pending = 0;
            end
         end
         if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) bus.tx_busy = 1'b0;
         end
         if (bus.tx_wr) begin
            bus.tx_busy = 1'b1;
            busy_left   = 4;
         end

         if (bus.wb_stb_o) begin
            stb_run++;
            check("busy_during_bus", {31'h0, busy}, 32'h1);
         end else if (stb_run != 0) begin
            last_stb_len = stb_run;
            stb_run      = 0;
         end

         if (bus.wb_ack_i) begin
            bus.wb_ack_i = 1'b0;
            bus.wb_dat_i = 32'hFFFF_FFFF;
            check("stb_dropped_after_ack", {31'h0, bus.wb_stb_o}, 32'h0);
         end else if (bus.wb_cyc_o && bus.wb_stb_o) begin
            stb_cnt++;
            if (stb_cnt == slave_ws + 1) begin
               wb_txn_t t;
               wb_txn_t e;
               bus.wb_ack_i = 1'b1;
               bus.wb_dat_i = slave_rd;
               stb_cnt      = 0;
               t.adr = bus.wb_adr_o;
               t.dat = bus.wb_dat_o;
               t.we  = bus.wb_we_o;
               wb_log.push_back(t);
               wb_count++;
               check("wb_expected", {31'h0, exp_wb.size() > 0}, 32'h1);
               if (exp_wb.size() > 0) begin
                  e = exp_wb.pop_front();
                  check("wb_adr", t.adr, e.adr);
                  check("wb_we", {31'h0, t.we}, {31'h0, e.we});
                  if (e.we) check("wb_dat_o", t.dat, e.dat);
               end
            end
         end
         prev_rx_ack = bus.rx_ack;
         prev_tx_wr  = bus.tx_wr;
      end
   end

   task automatic wait_ack();
      int k;
      for (k = 0; k < 200; k++) begin
         @(negedge clk);
         if (bus.rx_ack) break;
      end
      check("rx_ack_seen", {31'h0, bus.rx_ack}, 32'h1);
      bus.rx_avail = 1'b0;
      bus.rx_error = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic e);
      @(negedge clk);
      bus.rx_data  = b;
      bus.rx_error = e;
      bus.rx_avail = 1'b1;
      wait_ack();
   endtask

   task automatic wait_idle();
      int k;
      for (k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (exp_tx.size() == 0 && exp_wb.size() == 0 && !busy && !bus.tx_busy) break;
      end
      check("frame_complete", {31'h0, k < 3000}, 32'h1);
      check("busy_back_to_idle", {31'h0, busy}, 32'h0);
   endtask

   // Protocol model: derive the reply bytes and bus cycle from the frame, then play it.
   task automatic run_frame(input int len, input int err_at, input int ws, input logic [31:0] rd);
      int      last;
      wb_txn_t t;
      last       = (err_at >= 0) ? err_at : len - 1;
      lat_budget = 2;
      t.adr = {frame[1], frame[2], frame[3], frame[4]};
      t.dat = {frame[5], frame[6], frame[7], frame[8]};
      if (err_at >= 0) begin
         exp_tx.push_back(8'h15);
      end else if (frame[0] == 8'h50) begin
         exp_tx.push_back(8'h06);
      end else if (frame[0] == 8'h52) begin
         t.we = 1'b0;
         exp_wb.push_back(t);
         for (int i = 3; i >= 0; i--) exp_tx.push_back(rd[8*i +: 8]);
         lat_budget = 2 + ws;
      end else if (frame[0] == 8'h57) begin
         t.we = 1'b1;
         exp_wb.push_back(t);
         exp_tx.push_back(8'h06);
         lat_budget = 2 + ws;
      end else begin
         exp_tx.push_back(8'h15);
      end
      slave_ws         = ws;
      slave_rd         = rd;
      first_tx_pending = 1;
      for (int i = 0; i <= last; i++) send_byte(frame[i], i == err_at);
      wait_idle();
   endtask

   initial begin
      int tx0;
      int wb0;
      int k;
      reset        = 1'b1;
      bus.rx_data  = 8'h00;
      bus.rx_avail = 1'b0;
      bus.rx_error = 1'b0;
      bus.tx_busy  = 1'b0;
      bus.wb_dat_i = 32'h0;
      bus.wb_ack_i = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_rx_ack", {31'h0, bus.rx_ack}, 32'h0);
      check("rst_tx_wr", {31'h0, bus.tx_wr}, 32'h0);
      check("rst_tx_data", {24'h0, bus.tx_data}, 32'h0);
      check("rst_wb_adr", bus.wb_adr_o, 32'h0);
      check("rst_wb_dat", bus.wb_dat_o, 32'h0);
      check("rst_wb_ctl", {29'h0, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o}, 32'h0);
      check("rst_wb_sel", {28'h0, bus.wb_sel_o}, 32'hF);
      check("rst_busy", {31'h0, busy}, 32'h0);

      // Ping presented in the same cycle reset is released.
      exp_tx.push_back(8'h06);
      lat_budget       = 2;
      first_tx_pending = 1;
      @(negedge clk);
      reset        = 1'b0;
      bus.rx_data  = 8'h50;
      bus.rx_avail = 1'b1;
      wait_ack();
      wait_idle();
      check("ping_count", tx_count, 32'd1);
      check("ping_byte", {24'h0, tx_log[tx_log.size()-1]}, 32'h06);

      // Write with three wait states.
      frame = '{8'h57, 8'h00, 8'h00, 8'h10, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      run_frame(9, -1, 3, 32'h0);
      check("wr_count", wb_count, 32'd1);
      check("wr_adr_lit", wb_log[0].adr, 32'h0000_1000);
      check("wr_dat_lit", wb_log[0].dat, 32'hDEAD_BEEF);
      check("wr_we_lit", {31'h0, wb_log[0].we}, 32'h1);
      check("wr_stb_len", last_stb_len, 32'd4);
      check("wr_reply_lit", {24'h0, tx_log[tx_log.size()-1]}, 32'h06);

      // Read, zero wait states (one-clock bus cycle).
      tx0 = tx_count;
      frame = '{8'h52, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      run_frame(5, -1, 0, 32'h1234_5678);
      check("rd_stb_len", last_stb_len, 32'd1);
      check("rd_reply_count", tx_count - tx0, 32'd4);
      check("rd_b0", {24'h0, tx_log[tx0]},   32'h12);
      check("rd_b1", {24'h0, tx_log[tx0+1]}, 32'h34);
      check("rd_b2", {24'h0, tx_log[tx0+2]}, 32'h56);
      check("rd_b3", {24'h0, tx_log[tx0+3]}, 32'h78);

      // Unaligned read: low address bits pass through.
      frame = '{8'h52, 8'hA5, 8'h5A, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
      run_frame(5, -1, 1, 32'hCAFE_F00D);
      check("rd_unaligned_adr", wb_log[wb_log.size()-1].adr, 32'hA55A_0003);

      frame = '{8'h57, 8'hFF, 8'hFF, 8'hFF, 8'hFC, 8'h01, 8'h02, 8'h03, 8'h04};
      run_frame(9, -1, 0, 32'h0);

      // Error paths: unknown command, rx_error in address, in command, in data.
      wb0 = wb_count;
      tx0 = tx_count;
      frame = '{8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      run_frame(1, -1, 0, 32'h0);
      check("nak_byte_lit", {24'h0, tx_log[tx0]}, 32'h15);
      frame = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      run_frame(5, 1, 0, 32'h0);
      check("rxerr_nak_lit", {24'h0, tx_log[tx_log.size()-1]}, 32'h15);
      frame = '{8'h50, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      run_frame(1, 0, 0, 32'h0);
      frame = '{8'h57, 8'h00, 8'h00, 8'h20, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
      run_frame(9, 6, 0, 32'h0);
      check("err_no_wb", wb_count - wb0, 32'd0);
      check("err_reply_count", tx_count - tx0, 32'd4);

      // Partial frame followed by a long gap, then a ping.
      tx0 = tx_count;
      wb0 = wb_count;
`ifdef UART_WB_LOADER_TIMEOUT_EN
      exp_tx.push_back(8'h06);
      lat_budget       = 2;
      first_tx_pending = 1;
`endif
      send_byte(8'h57, 1'b0);
      send_byte(8'h00, 1'b0);
      repeat (105) @(negedge clk);
`ifdef UART_WB_LOADER_TIMEOUT_EN
      check("timeout_busy", {31'h0, busy}, 32'h0);
`else
      check("timeout_busy", {31'h0, busy}, 32'h1);
`endif
      send_byte(8'h50, 1'b0);
      repeat (60) @(negedge clk);
`ifdef UART_WB_LOADER_TIMEOUT_EN
      check("timeout_reply_count", tx_count - tx0, 32'd1);
      check("timeout_reply_lit", {24'h0, tx_log[tx_log.size()-1]}, 32'h06);
`else
      check("timeout_reply_count", tx_count - tx0, 32'd0);
`endif
      check("timeout_no_wb", wb_count - wb0, 32'd0);
      @(negedge clk) reset = 1'b1;
      @(negedge clk) reset = 1'b0;
      check("timeout_busy_after_reset", {31'h0, busy}, 32'h0);

      // Reset while the bus cycle is stalled by the slave.
      tx0      = tx_count;
      wb0      = wb_count;
      slave_ws = 50;
      frame = '{8'h57, 8'h00, 8'h00, 8'h30, 8'h00, 8'h55, 8'h66, 8'h77, 8'h88};
      for (int i = 0; i < 9; i++) send_byte(frame[i], 1'b0);
      for (k = 0; k < 20; k++) begin
         if (bus.wb_stb_o) break;
         @(negedge clk);
      end
      check("stall_stb_high", {31'h0, bus.wb_stb_o}, 32'h1);
      #2 reset = 1'b1;
      #1;
      check("rst_mid_cyc", {31'h0, bus.wb_cyc_o}, 32'h0);
      check("rst_mid_stb", {31'h0, bus.wb_stb_o}, 32'h0);
      check("rst_mid_busy", {31'h0, busy}, 32'h0);
      repeat (2) @(negedge clk);
      reset    = 1'b0;
      slave_ws = 0;
      repeat (30) @(negedge clk);
      check("rst_mid_no_tx", tx_count - tx0, 32'd0);
      check("rst_mid_no_wb", wb_count - wb0, 32'd0);

      // Block still usable afterwards.
      frame = '{8'h50, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      run_frame(1, -1, 0, 32'h0);
      check("final_exp_tx_drained", exp_tx.size(), 32'd0);
      check("final_exp_wb_drained", exp_wb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
